passcode_checker: RTL and testbench

- Consumes the one-cycle `key_pulse` and the `key_value` digit (1..9) from the key-input stage directly upstream.
- Assembles a PW_LEN-digit entry and compares it with the stored passcode.
- Drives the door-open output for a fixed time, or flags an error.
- Counts consecutive failures; at MAX_FAIL it locks the keypad out for a fixed time.

---
 rtl/passcode_checker.sv | 126 ++++++++++++
 tb/tb_passcode_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/passcode_checker.sv
// passcode_checker: PW_LEN-digit keypad passcode checker with timed door-open and failure lockout.
// Define ENTRY_TIMEOUT_EN to discard a partial entry after TIMEOUT_CYCLES idle cycles.
module passcode_checker #(
  parameter int PW_LEN = 4,
  parameter logic [4*PW_LEN-1:0] PASSWORD = 16'h1234,
  parameter int OPEN_CYCLES = 8,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 20
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic key_pulse,
  input  logic [3:0] key_value,
  output logic door_open,
  output logic error_pulse,
  output logic locked,
  output logic [$clog2(PW_LEN+1)-1:0] digit_count,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);
  localparam int BW = 4*PW_LEN;
  localparam int DW = $clog2(PW_LEN+1);
  localparam int FW = $clog2(MAX_FAIL+1);
  localparam int TMAX = OPEN_CYCLES > LOCK_CYCLES
    ? (OPEN_CYCLES > TIMEOUT_CYCLES ? OPEN_CYCLES : TIMEOUT_CYCLES)
    : (LOCK_CYCLES > TIMEOUT_CYCLES ? LOCK_CYCLES : TIMEOUT_CYCLES);
  localparam int TW = $clog2(TMAX+1);
  typedef enum logic [1:0] {ENTRY, CHECK, OPEN, LOCKOUT} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] digits_q, digits_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] cnt_d;
  logic [FW-1:0] fail_d, fail_inc;
  logic door_d, err_d, lock_d, accept;
`ifdef ENTRY_TIMEOUT_EN
  logic [TW-1:0] idle_q, idle_d;
`endif
  assign accept = key_pulse && key_value != 4'd0 && key_value <= 4'd9;
  assign fail_inc = fail_count == FW'(MAX_FAIL) ? fail_count : fail_count + FW'(1);
  always_comb begin
    state_d = state_q;
    digits_d = digits_q;
    cnt_d = digit_count;
    fail_d = fail_count;
    timer_d = timer_q;
    door_d = door_open;
    lock_d = locked;
    err_d = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    idle_d = '0;
`endif
    case (state_q)
      ENTRY: begin
        if (accept) begin
          digits_d = (digits_q << 4) | BW'(key_value);
          cnt_d = digit_count + DW'(1);
          state_d = cnt_d == DW'(PW_LEN) ? CHECK : ENTRY;
        end
`ifdef ENTRY_TIMEOUT_EN
        idle_d = (accept || digit_count == '0) ? '0 : idle_q + TW'(1);
        // a digit landing in the expiry cycle takes precedence over the clear
        if (!accept && idle_q == TW'(TIMEOUT_CYCLES)) begin
          digits_d = '0;
          cnt_d = '0;
          idle_d = '0;
        end
`endif
      end
      CHECK: begin
        digits_d = '0;
        cnt_d = '0;
        if (digits_q == PASSWORD) begin
          state_d = OPEN;
          door_d = 1'b1;
          fail_d = '0;
          timer_d = TW'(OPEN_CYCLES - 1);
        end else begin
          err_d = 1'b1;
          fail_d = fail_inc;
          lock_d = fail_inc == FW'(MAX_FAIL);
          state_d = lock_d ? LOCKOUT : ENTRY;
          timer_d = lock_d ? TW'(LOCK_CYCLES - 1) : timer_q;
        end
      end
      OPEN: begin
        timer_d = timer_q == '0 ? timer_q : timer_q - TW'(1);
        door_d = timer_q != '0;
        state_d = timer_q == '0 ? ENTRY : OPEN;
      end
      LOCKOUT: begin
        timer_d = timer_q == '0 ? timer_q : timer_q - TW'(1);
        lock_d = timer_q != '0;
        fail_d = timer_q == '0 ? '0 : fail_count;
        state_d = timer_q == '0 ? ENTRY : LOCKOUT;
      end
      default: state_d = ENTRY;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ENTRY;
      digits_q <= '0;
      digit_count <= '0;
      fail_count <= '0;
      timer_q <= '0;
      door_open <= 1'b0;
      error_pulse <= 1'b0;
      locked <= 1'b0;
    end else begin
      state_q <= state_d;
      digits_q <= digits_d;
      digit_count <= cnt_d;
      fail_count <= fail_d;
      timer_q <= timer_d;
      door_open <= door_d;
      error_pulse <= err_d;
      locked <= lock_d;
    end
  end
`ifdef ENTRY_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) idle_q <= '0;
    else idle_q <= idle_d;
  end
`endif
endmodule

// File: tb/tb_passcode_checker.sv
// tb_passcode_checker: directed scoreboard bench; the monitor compares door/lock windows and error pulses against queued expectations.
module tb_passcode_checker;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic key_pulse = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic door_open, error_pulse, locked;
  logic [2:0] digit_count;
  logic [1:0] fail_count;
  int total = 0;
  int bad = 0;
  int door_len = 0;
  int lock_len = 0;
  typedef struct {int kind; int val;} ev_t;
  ev_t q[$];
  always #5 CLK = ~CLK;
  passcode_checker dut (
    .CLK(CLK), .RESET_N(RESET_N), .key_pulse(key_pulse), .key_value(key_value),
    .door_open(door_open), .error_pulse(error_pulse), .locked(locked),
    .digit_count(digit_count), .fail_count(fail_count)
  );
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // kind 0: door window length, 1: fail_count seen with error_pulse, 2: lock window length
  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d expected none", kind, val);
    end else begin
      e = q.pop_front();
      check("event_kind", kind, e.kind);
      check($sformatf("event_val_k%0d", e.kind), val, e.val);
    end
  endtask
  always @(negedge CLK) begin
    if (!RESET_N) begin
      door_len = 0;
      lock_len = 0;
    end else begin
      if (error_pulse) expect_ev(1, int'(fail_count));
      if (door_open) door_len++;
      else if (door_len != 0) begin
        expect_ev(0, door_len);
        door_len = 0;
      end
      if (locked) lock_len++;
      else if (lock_len != 0) begin
        expect_ev(2, lock_len);
        lock_len = 0;
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic press(input logic [3:0] v);
    key_pulse = 1'b1;
    key_value = v;
    @(posedge CLK);
    #1;
    key_pulse = 1'b0;
    key_value = 4'd0;
  endtask
  task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    press(a); idle(2);
    press(b); idle(2);
    press(c); idle(2);
    press(d);
  endtask
  task automatic pulse_reset();
    RESET_N = 1'b0;
    #1;
    check("rst_door", int'(door_open), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_digits", int'(digit_count), 0);
    check("rst_fail", int'(fail_count), 0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask
  initial begin
    @(posedge CLK);
    #1;
    check("reset_door", int'(door_open), 0);
    check("reset_err", int'(error_pulse), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_digits", int'(digit_count), 0);
    check("reset_fail", int'(fail_count), 0);
    RESET_N = 1'b1;
    idle(1);
    // correct code, digit count steps, door latency and window, key during OPEN
    press(1); check("dc1", int'(digit_count), 1); idle(2);
    press(2); check("dc2", int'(digit_count), 2); idle(2);
    press(3); check("dc3", int'(digit_count), 3); idle(2);
    q.push_back('{0, 8});
    press(4); check("dc4", int'(digit_count), 4); check("door_in_check", int'(door_open), 0);
    idle(1); check("door_latency", int'(door_open), 1); check("fail_ok", int'(fail_count), 0);
    idle(2); press(5); check("key_in_open", int'(digit_count), 0);
    idle(4); check("door_last", int'(door_open), 1);
    idle(1); check("door_closed", int'(door_open), 0); check("dc_after_open", int'(digit_count), 0);
    idle(2);
    // wrong code then correct code clears fail count
    q.push_back('{1, 1});
    enter(1, 2, 3, 5);
    idle(1); check("err_pulse", int'(error_pulse), 1); check("fail1", int'(fail_count), 1);
    check("dc_after_err", int'(digit_count), 0); check("door_err", int'(door_open), 0);
    idle(1); check("err_once", int'(error_pulse), 0);
    q.push_back('{0, 8});
    enter(1, 2, 3, 4);
    idle(1); check("door_retry", int'(door_open), 1); check("fail_cleared", int'(fail_count), 0);
    idle(10);
    // three failures lead to lockout
    for (int i = 1; i <= 3; i++) begin
      q.push_back('{1, i});
      if (i == 3) q.push_back('{2, 16});
      enter(9, 9, 9, 9);
      idle(1);
      check($sformatf("fail_step%0d", i), int'(fail_count), i);
      if (i < 3) idle(1);
    end
    check("locked_start", int'(locked), 1);
    idle(1); press(1); check("key_in_lock", int'(digit_count), 0);
    idle(13); check("locked_last", int'(locked), 1);
    idle(1); check("locked_end", int'(locked), 0); check("fail_after_lock", int'(fail_count), 0);
    q.push_back('{0, 8});
    enter(1, 2, 3, 4);
    idle(1); check("door_after_lock", int'(door_open), 1);
    idle(10);
    // invalid digits ignored mid-entry
    press(1); idle(2);
    press(0); check("ignore_0", int'(digit_count), 1); idle(2);
    press(12); check("ignore_12", int'(digit_count), 1); idle(2);
    press(2); check("dc_after_bad", int'(digit_count), 2); idle(2);
    q.push_back('{0, 8});
    press(3); idle(2); press(4);
    idle(1); check("door_bad_keys", int'(door_open), 1);
    idle(10);
    // asynchronous reset during partial entry, OPEN and LOCKOUT
    press(1); idle(2); press(2); check("partial_dc", int'(digit_count), 2);
    pulse_reset();
    enter(1, 2, 3, 4);
    idle(3); check("open_before_rst", int'(door_open), 1);
    pulse_reset();
    idle(2);
    for (int i = 1; i <= 3; i++) begin
      q.push_back('{1, i});
      enter(9, 9, 9, 9);
      idle(2);
    end
    idle(1); check("lock_before_rst", int'(locked), 1);
    pulse_reset();
    q.push_back('{0, 8});
    enter(1, 2, 3, 4);
    idle(1); check("door_after_rst", int'(door_open), 1);
    idle(10);
`ifdef ENTRY_TIMEOUT_EN
    press(1); idle(2); press(2);
    idle(19); check("to_pending", int'(digit_count), 2);
    idle(3); check("to_cleared", int'(digit_count), 0); check("to_fail", int'(fail_count), 0);
    q.push_back('{0, 8});
    enter(1, 2, 3, 4);
    idle(1); check("door_after_to", int'(door_open), 1);
    idle(10);
`endif
    idle(2);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
